// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration-time helpers for the extended synchronous FIFO.
package sync_fifo_pkg;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } read_mode_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int af, input int depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_ok(input int ae, input int depth);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read register doubles as the FIFO output register.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, occupancy count, sticky error flags and flush.
//
// Handshake: a write is taken on a clock edge where wr_enable=1 and either the
// FIFO is not full or a read is taken on the same edge; a read is taken where
// rd_enable=1 and empty=0. Requests that are not taken leave all state untouched
// and set the matching sticky error flag.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_enable,
  input  logic                 rd_enable,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int         ADDR_W = addr_w(DEPTH);
  localparam int         CNT_W  = cnt_w(DEPTH);
  localparam read_mode_e MODE   = (FWFT != 0) ? RD_FWFT : RD_STD;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_ext: DEPTH must be a power of two and at least 4");
  end
  if (!af_ok(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("sync_fifo_ext: AF_THRESH out of range 1..DEPTH");
  end
  if (!ae_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_ext: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              out_valid;
  logic              rd_ok;
  logic              wr_ok;
  logic              has_stored;
  logic              ram_rd;
  logic              wr_go;
  logic              rd_go;

  // Status flags decode only registered state, so no input reaches them combinationally.
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));
  assign empty        = (MODE == RD_FWFT) ? !out_valid : (count == '0);

  // Request acceptance and RAM read scheduling.
  always_comb begin
    rd_ok      = rd_enable && !empty;
    wr_ok      = wr_enable && (!full || rd_ok);
    // Words still in the RAM, i.e. not yet moved to the FWFT output register.
    has_stored = (count - CNT_W'(out_valid)) != '0;
    ram_rd     = 1'b0;
    if (MODE == RD_FWFT) ram_rd = has_stored && (!out_valid || rd_ok);
    else                 ram_rd = rd_ok;
    wr_go      = wr_ok && !reset && !clear;
    rd_go      = ram_rd && !reset && !clear;
  end

  // Pointers, occupancy and sticky errors; flush behaves like reset except for data_out.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      if (wr_enable && !wr_ok) overflow  <= 1'b1;
      if (rd_enable && empty)  underflow <= 1'b1;
    end
  end

  // FWFT output-word valid bit: set when the head is fetched, cleared when popped dry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid <= 1'b0;
    end else if (MODE == RD_FWFT) begin
      if (ram_rd)     out_valid <= 1'b1;
      else if (rd_ok) out_valid <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_go),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_go),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised successor to the basic synchronous FIFO. Single-clock data buffer with a configurable read mode: standard registered read, or first-word-fall-through (FWFT). Adds programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. Sits between producer/consumer blocks in the same clock domain and is a drop-in superset of the existing sync FIFO port set.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous flush; empties the FIFO and clears error flags
wr_enable  in  1  write request
rd_enable  in  1  read request (FWFT: pop/acknowledge current head)
data_in  in  WIDTH  write data
data_out  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  standard: count == 0; FWFT: no valid word on data_out
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and no read accepted that cycle
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (reset=1 at clk edge): pointers=0, count=0, data_out=0, full=0, empty=1, almost_empty=1, almost_full=0, overflow=0, underflow=0. reset has priority over clear and all requests.
- clear=1: same as reset for pointers, count, flags and sticky errors. data_out holds its value. Requests in the same cycle are ignored.
- Read accept: rd_ok = rd_enable && !empty.
- Write accept: wr_ok = wr_enable && (!full || rd_ok). A write on full is accepted when a read is accepted in the same cycle.
- count next = count + wr_ok - rd_ok. Simultaneous accepted read and write leaves count unchanged.
- Write and read pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full, empty, almost_full and almost_empty are pure functions of the registered count (standard mode), so they are valid in the same cycle as count.
- Standard mode:
  - data_out is registered and updates one cycle after an accepted read with mem[rd_ptr].
  - It holds its value otherwise.
  - A write to an empty FIFO plus a read in the same cycle: the read is rejected.
- FWFT mode:
  - The head word is presented on data_out with empty=0 no later than 2 cycles after the write into an empty FIFO.
  - rd_enable pops the head; the next word, if present, appears on the following cycle.
  - count includes the word on data_out.
  - empty is deasserted only when data_out is valid.
- overflow sets on wr_enable && !wr_ok. underflow sets on rd_enable && empty. Both remain set until reset or clear. A rejected request does not change pointers, count or memory.
- No combinational path from inputs to full/empty/count.

Decomposition:
- Package sync_fifo_pkg: ADDR_W/CNT_W derivation functions, read-mode enum (STD, FWFT), and threshold legality checks used in elaboration-time asserts.
- One sub-module fifo_mem: simple dual-port RAM, 1 write port and 1 synchronous read port, WIDTH x DEPTH.
- Top block holds pointers, count, flags and the FWFT output stage (one output register plus valid bit).

Test Plan:
1. Reset, then write 16 words 0x01..0x10 (WIDTH=8, DEPTH=16, AF=14, AE=2) -> count 16, full=1, almost_full=1 from count 14, empty=0; 17th write sets overflow=1, count stays 16.
2. Read all 16 in standard mode -> data_out 0x01..0x10 each one cycle after rd_enable; empty=1 at count 0; extra read sets underflow=1 and data_out holds 0x10.
3. Full FIFO with wr_enable and rd_enable high together for 4 cycles -> count stays 16, overflow stays 0, output order preserved.
4. Pointer wrap: 10 writes, 10 reads, then 10 writes and 10 reads with values 0xA0..0xA9 -> data read back in order, count returns to 0.
5. FWFT=1: single write of 0x5A into empty FIFO -> data_out=0x5A with empty=0 within 2 cycles, before any rd_enable; rd_enable pops it -> empty=1, count=0.
6. Fill to 8, assert clear (and in a separate run reset) mid-stream with wr_enable=1 -> next cycle count=0, empty=1, overflow=0, underflow=0, and the concurrent write is dropped.
